// File: rtl/pc_seq_pkg.sv
// Shared op codes and types for the program-counter sequencer.
// Imported by pc_sequencer and its return stack.
package pc_seq_pkg;

  typedef logic [2:0] pc_op_t;

  localparam pc_op_t OP_NEXT    = 3'd0;
  localparam pc_op_t OP_JUMP    = 3'd1;
  localparam pc_op_t OP_BRANCH  = 3'd2;
  localparam pc_op_t OP_CALL    = 3'd3;
  localparam pc_op_t OP_RET     = 3'd4;
  localparam pc_op_t OP_RECOUNT = 3'd5;
  localparam pc_op_t OP_HOLD    = 3'd6;

  function automatic int unsigned depth_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO of return addresses; it only counts and stores, and
// leaves overflow/underflow policy to the sequencer.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned DW    = depth_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [DW-1:0] r_depth;
  logic [DW-1:0] w_depth_m1;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;

  assign w_depth_m1 = r_depth - DW'(1);
  assign w_wr_idx   = r_depth[IW-1:0];
  assign w_rd_idx   = w_depth_m1[IW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_depth <= '0;
    end else if (clr) begin
      r_depth <= '0;
    end else if (push) begin
      r_depth <= r_depth + DW'(1);
    end else if (pop) begin
      r_depth <= w_depth_m1;
    end
  end

  // Contents need no reset: depth alone says what is valid.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  assign top   = r_mem[w_rd_idx];
  assign depth = r_depth;
  assign full  = (r_depth == DW'(DEPTH));
  assign empty = (r_depth == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with return-address stack and sticky misuse flag.
// Define PC_SEQ_TRACE_EN to add last_src/last_vld transfer tracing.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned DW = depth_w(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  pc_op_t            op,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  input  logic              cond,
  output logic [ADDR_W-1:0] pc,
  output logic [DW-1:0]     depth,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err
`ifdef PC_SEQ_TRACE_EN
  ,
  output logic [ADDR_W-1:0] last_src,
  output logic              last_vld
`endif
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_err;

  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_top;
  logic              w_push;
  logic              w_pop;
  logic              w_err_set;
  logic              w_xfer;
  logic              w_recount;
  logic              w_full;
  logic              w_empty;

  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    w_xfer    = 1'b0;
    w_recount = 1'b0;
    if (en) begin
      unique case (op)
        OP_NEXT: begin
          w_pc_nxt = w_pc_inc;
        end
        OP_JUMP: begin
          w_pc_nxt = target;
          w_xfer   = 1'b1;
        end
        OP_BRANCH: begin
          if (cond) begin
            w_pc_nxt = r_pc + offset;
            w_xfer   = 1'b1;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
        OP_CALL: begin
          // A call into a full stack is dropped, not taken.
          if (w_full) begin
            w_err_set = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = target;
            w_xfer   = 1'b1;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_err_set = 1'b1;
          end else begin
            w_pop    = 1'b1;
            w_pc_nxt = w_top;
            w_xfer   = 1'b1;
          end
        end
        OP_RECOUNT: begin
          w_recount = 1'b1;
          w_pc_nxt  = RESET_VEC;
        end
        default: begin
          w_pc_nxt = r_pc;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= RESET_VEC;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_recount) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W),
    .DW    (DW)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_recount),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_top),
    .depth     (depth),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign pc          = r_pc;
  assign err         = r_err;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

`ifdef PC_SEQ_TRACE_EN
  logic [ADDR_W-1:0] r_last_src;
  logic              r_last_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_src <= '0;
      r_last_vld <= 1'b0;
    end else if (w_recount) begin
      r_last_src <= '0;
      r_last_vld <= 1'b0;
    end else if (w_xfer) begin
      r_last_src <= r_pc;
      r_last_vld <= 1'b1;
    end
  end

  assign last_src = r_last_src;
  assign last_vld = r_last_vld;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus random checks of pc_sequencer against a queue model.
// Trace ports are checked when PC_SEQ_TRACE_EN is defined.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] op;
  logic [7:0] target;
  logic [7:0] offset;
  logic       cond;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       stack_full;
  logic       stack_empty;
  logic       err;
`ifdef PC_SEQ_TRACE_EN
  logic [7:0] last_src;
  logic       last_vld;
`endif

  int total = 0;
  int bad   = 0;

  int m_pc;
  int m_err;
  int m_src;
  int m_vld;
  int m_stk[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_VEC   (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .op          (op),
    .target      (target),
    .offset      (offset),
    .cond        (cond),
    .pc          (pc),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err         (err)
`ifdef PC_SEQ_TRACE_EN
    ,
    .last_src    (last_src),
    .last_vld    (last_vld)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m_pc  = 0;
    m_err = 0;
    m_src = 0;
    m_vld = 0;
    m_stk.delete();
  endtask

  task automatic m_xfer(input int from);
    m_src = from;
    m_vld = 1;
  endtask

  task automatic model(input logic e, input logic [2:0] o,
                       input int t, input int off,
                       input logic c);
    int old;
    old = m_pc;
    if (!e) return;
    case (o)
      0: m_pc = (m_pc + 1) % 256;
      1: begin m_pc = t; m_xfer(old); end
      2: begin
        if (c) begin
          m_pc = (m_pc + off) % 256;
          m_xfer(old);
        end else begin
          m_pc = (m_pc + 1) % 256;
        end
      end
      3: begin
        if (m_stk.size() == 4) begin
          m_err = 1;
        end else begin
          m_stk.push_back((m_pc + 1) % 256);
          m_pc = t;
          m_xfer(old);
        end
      end
      4: begin
        if (m_stk.size() == 0) begin
          m_err = 1;
        end else begin
          m_pc = m_stk.pop_back();
          m_xfer(old);
        end
      end
      5: m_clear();
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".depth"}, 32'(depth), 32'(m_stk.size()));
    chk({tag, ".full"}, 32'(stack_full), 32'(m_stk.size() == 4));
    chk({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef PC_SEQ_TRACE_EN
    chk({tag, ".lsrc"}, 32'(last_src), 32'(m_src));
    chk({tag, ".lvld"}, 32'(last_vld), 32'(m_vld));
`endif
  endtask

  task automatic step(input string tag, input logic e,
                      input logic [2:0] o, input logic [7:0] t,
                      input logic [7:0] off, input logic c);
    en     = e;
    op     = o;
    target = t;
    offset = off;
    cond   = c;
    @(posedge clk);
    model(e, o, int'(t), int'(off), c);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b0;
    op     = 3'd6;
    target = '0;
    offset = '0;
    cond   = 1'b0;
    m_clear();
    #12;
    check_all("rst");
    chk("rst_empty", 32'(stack_empty), 32'd1);
    reset = 1'b0;

    step("next1", 1, 0, 0, 0, 0);
    step("next2", 1, 0, 0, 0, 0);
    step("next3", 1, 0, 0, 0, 0);
    chk("next3_lit", 32'(pc), 32'h03);

    step("j_ff", 1, 1, 8'hFF, 0, 0);
    step("wrap", 1, 0, 0, 0, 0);
    chk("wrap_lit", 32'(pc), 32'h00);

    step("j_10", 1, 1, 8'h10, 0, 0);
    step("br_t", 1, 2, 0, 8'hF0, 1);
    chk("br_t_lit", 32'(pc), 32'h00);
    step("j_10b", 1, 1, 8'h10, 0, 0);
    step("br_n", 1, 2, 0, 8'hF0, 0);
    chk("br_n_lit", 32'(pc), 32'h11);

    step("j_05", 1, 1, 8'h05, 0, 0);
    step("call", 1, 3, 8'h40, 0, 0);
    chk("call_lit", 32'(pc), 32'h40);
    step("ret", 1, 4, 0, 0, 0);
    chk("ret_lit", 32'(pc), 32'h06);

    for (int i = 0; i < 5; i++) begin
      step("ncall", 1, 3, 8'(8'h50 + 8'(i * 16)), 0, 0);
    end
    chk("ovf_pc", 32'(pc), 32'h80);
    chk("ovf_full", 32'(stack_full), 32'd1);
    chk("ovf_err", 32'(err), 32'd1);
    step("recount", 1, 5, 0, 0, 0);
    chk("rc_err", 32'(err), 32'd0);

    step("j_22", 1, 1, 8'h22, 0, 0);
    step("udf", 1, 4, 0, 0, 0);
    chk("udf_err", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step("stall", 0, 1, 8'h80, 0, 0);
    end
    chk("stall_pc", 32'(pc), 32'h22);

    step("err_run", 1, 0, 0, 0, 0);
    step("c1", 1, 3, 8'h70, 0, 0);
    en     = 1'b1;
    op     = 3'd3;
    target = 8'h90;
    #2;
    reset = 1'b1;
    #1;
    m_clear();
    check_all("async_rst");
    #2;
    reset = 1'b0;

`ifdef PC_SEQ_TRACE_EN
    step("j_33", 1, 1, 8'h33, 0, 0);
    step("tr_j", 1, 1, 8'h44, 0, 0);
    chk("tr_src", 32'(last_src), 32'h33);
    chk("tr_vld", 32'(last_vld), 32'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [2:0] o;
      logic       e;
      o = 3'($urandom_range(0, 7));
      if (o == 3'd5 && $urandom_range(0, 3) != 0) o = 3'd3;
      e = ($urandom_range(0, 9) != 0);
      step("rnd", e, o, 8'($urandom), 8'($urandom),
           1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
